rtype_instr_encoder: RTL and testbench
======================================

Name: rtype_instr_encoder

Overview:
- Encoder side of the ALU function-field interface. Takes R-type instruction requests (3-bit alu_op code plus register fields) and emits complete 32-bit MIPS R-type instruction words.
- The func field in each emitted word is chosen so that the ALU-control decoder maps it back to the same alu_op.
- Requests are buffered in a small FIFO. Words leave through a valid/ready port that writes sequential instruction-memory addresses. The block loads test programs into the single-cycle R-type datapath.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- ADDR_W, 8, width of the instruction-memory word-address counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- in_alu_op  input  3  requested ALU operation code.
- in_rs  input  5  source register 1.
- in_rt  input  5  source register 2.
- in_rd  input  5  destination register.
- in_shamt  input  5  shift amount (used only with SHAMT_EN).
- out_valid  output  1  encoded word available.
- out_ready  input  1  instruction memory accepts the word.
- out_instr  output  32  encoded R-type word.
- out_addr  output  ADDR_W  word address for out_instr.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.
- err  output  1  sticky flag: illegal alu_op was presented.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_addr=0, level=0, err=0; FIFO pointers=0.
- Word format: [31:26]=000000, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=shamt, [5:0]=func.
- Encode table (alu_op -> func):
  - 000 -> 100100 (and)
  - 001 -> 100101 (or)
  - 010 -> 100000 (add)
  - 100 -> 100010 (sub)
  - 101 -> 000010 (srl)
  - 110 -> 100110 (xor)
  - 111 -> 100111 (nor)
  - 011 is illegal.
- Encoding is combinational at the input. The FIFO stores finished 32-bit words.
- Accept: a request is accepted when in_valid && in_ready. in_ready = (level != DEPTH).
- Illegal op: when alu_op=011 is accepted, it is consumed (handshake completes), nothing is pushed, and err is set. err stays set until reset.
- Latency: a word accepted in cycle N drives out_valid=1 in cycle N+1.
- Output: out_valid = (level != 0). out_instr is the FIFO head, held stable while out_valid && !out_ready.
- Pop: on out_valid && out_ready, the head is popped and out_addr increments by 1. out_addr wraps from 2^ADDR_W-1 to 0 with no flag. out_addr changes only on a pop.
- Simultaneous push and pop, level strictly between 0 and DEPTH: both occur and level is unchanged.
- Full: in_ready=0. A pop in the same cycle does not enable a push; in_ready is recomputed next cycle.
- Empty: out_valid=0. out_ready is ignored and out_addr holds.
- Pointer wrap: read and write pointers wrap modulo DEPTH. level is derived from a counter, not from pointer difference.
- Reset mid-operation: all buffered words are discarded, out_addr returns to 0, err clears. No partial word is ever emitted.
- out_instr when empty: holds the last head value. It is don't-care, but must not be X after reset.

Optional Feature:
- Macro: RTYPE_ENC_SHAMT_EN.
- Defined: shamt field [10:6] = in_shamt when alu_op=101 (srl); 0 for every other op.
- Undefined: shamt field is always 0 and in_shamt is ignored; the port remains present.

Test Plan:
- Reset, then push alu_op=010, rs=1, rt=2, rd=3 -> next cycle out_valid=1, out_instr=0x00221820, out_addr=0. Pop -> out_addr=1, level=0.
- Push all 7 legal ops with out_ready=0 and DEPTH=4 -> in_ready=0 after 4 accepts, level=4. Drain with out_ready=1 -> func sequence 100100, 100101, 100000, 100010, then the remaining 3 in order; out_addr reaches 7.
- Round trip: each out_instr[5:0] is fed through the ALU-control decoder -> decoded alu_op equals the pushed alu_op for all 7 legal codes.
- Push alu_op=011 -> handshake completes, level stays 0, err=1. A following legal push is encoded normally, and err remains 1.
- ADDR_W=2: pop 5 words -> out_addr sequence 0, 1, 2, 3, 0. Assert reset with level=3 -> level=0, out_valid=0, out_addr=0, err=0 immediately, without waiting for a clock edge.
- With RTYPE_ENC_SHAMT_EN: push srl with rt=4, rd=5, shamt=3 -> out_instr=0x000428C2. Without the macro -> 0x00042802.

Source files
------------

// File: rtl/rtype_instr_encoder_if.sv
// Request/result bundle for rtype_instr_encoder: request handshake in, encoded
// word handshake out, plus FIFO occupancy and the sticky illegal-op flag.
interface rtype_instr_encoder_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [2:0]                 in_alu_op;
  logic [4:0]                 in_rs;
  logic [4:0]                 in_rt;
  logic [4:0]                 in_rd;
  logic [4:0]                 in_shamt;
  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                out_instr;
  logic [ADDR_W-1:0]          out_addr;
  logic [$clog2(DEPTH):0]     level;
  logic                       err;

  // Request producer / instruction-memory side.
  modport master (
    output in_valid, in_alu_op, in_rs, in_rt, in_rd, in_shamt, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, level, err
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_alu_op, in_rs, in_rt, in_rd, in_shamt, out_ready,
    output in_ready, out_valid, out_instr, out_addr, level, err
  );
endinterface

// File: rtl/rtype_instr_encoder.sv
// Encodes alu_op requests into MIPS R-type words, buffers them in a FIFO and
// writes them to sequential instruction-memory addresses. RTYPE_ENC_SHAMT_EN
// enables the shamt field for srl.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid-side payload must be held while valid && !ready.
module rtype_instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  rtype_instr_encoder_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  logic [5:0]  func;
  logic [4:0]  shamt;
  logic        legal;
  logic [31:0] word;
  logic        accept;
  logic        push;
  logic        pop;

  // func codes are the inverse of the ALU-control decoder table.
  always_comb begin
    func  = 6'b000000;
    legal = 1'b1;
    case (bus.in_alu_op)
      3'b000:  func = 6'b100100;
      3'b001:  func = 6'b100101;
      3'b010:  func = 6'b100000;
      3'b100:  func = 6'b100010;
      3'b101:  func = 6'b000010;
      3'b110:  func = 6'b100110;
      3'b111:  func = 6'b100111;
      default: legal = 1'b0;
    endcase
  end

`ifdef RTYPE_ENC_SHAMT_EN
  assign shamt = (bus.in_alu_op == 3'b101) ? bus.in_shamt : 5'd0;
`else
  assign shamt = 5'd0;
`endif

  assign word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, shamt, func};

  assign bus.in_ready  = (count != LVL_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign accept        = bus.in_valid && bus.in_ready;
  // Illegal ops complete the handshake but never occupy a slot.
  assign push          = accept && legal;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.out_instr = mem[rd_ptr];
  assign bus.out_addr  = addr_q;
  assign bus.level     = count;
  assign bus.err       = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        addr_q <= addr_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
      if (accept && !legal) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rtype_instr_encoder.sv
// Self-checking bench for rtype_instr_encoder: directed cases plus a random
// stream, with a reference encoder/decoder feeding an expected-word queue.
module tb_rtype_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;

  logic clk;
  logic reset;

  rtype_instr_encoder_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) ifc ();

  rtype_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  logic [31:0]       exp_q[$];
  logic [2:0]        op_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  logic              exp_err  = 1'b0;
  int                rdy_mode = 0;  // 0: hold low, 1: always ready, 2: random

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder, written from the instruction table.
  function automatic logic [31:0] enc_model(input logic [2:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [4:0] sh);
    logic [5:0] f;
    logic [4:0] s;
    f = 6'd0;
    case (op)
      3'd0: f = 6'h24;
      3'd1: f = 6'h25;
      3'd2: f = 6'h20;
      3'd4: f = 6'h22;
      3'd5: f = 6'h02;
      3'd6: f = 6'h26;
      3'd7: f = 6'h27;
      default: f = 6'd0;
    endcase
    s = 5'd0;
`ifdef RTYPE_ENC_SHAMT_EN
    if (op == 3'd5) s = sh;
`endif
    return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(s) << 6) | 32'(f);
  endfunction

  // ALU-control decoder: func -> alu_op.
  function automatic logic [2:0] alu_ctrl_decode(input logic [5:0] f);
    case (f)
      6'h24:   return 3'd0;
      6'h25:   return 3'd1;
      6'h20:   return 3'd2;
      6'h22:   return 3'd4;
      6'h02:   return 3'd5;
      6'h26:   return 3'd6;
      6'h27:   return 3'd7;
      default: return 3'd3;
    endcase
  endfunction

  // driver
  task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh);
    int n;
    @(negedge clk);
    ifc.in_valid  = 1'b1;
    ifc.in_alu_op = op;
    ifc.in_rs     = rs;
    ifc.in_rt     = rt;
    ifc.in_rd     = rd;
    ifc.in_shamt  = sh;
    n = 0;
    while (!ifc.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      check("in_ready_timeout", 32'(ifc.in_ready), 32'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    if (op != 3'b011) begin
      exp_q.push_back(enc_model(op, rs, rt, rd, sh));
      op_q.push_back(op);
    end else begin
      exp_err = 1'b1;
    end
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ifc.out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: compare each word as it is handed to instruction memory
  initial begin
    logic [31:0] e;
    logic [2:0]  o;
    forever begin
      @(negedge clk);
      if (!reset) begin
        case (rdy_mode)
          0:       ifc.out_ready = 1'b0;
          1:       ifc.out_ready = 1'b1;
          default: ifc.out_ready = 1'($urandom_range(0, 1));
        endcase
        if (ifc.out_valid && ifc.out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_word", 32'(ifc.out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            o = op_q.pop_front();
            check("out_instr", ifc.out_instr, e);
            check("out_addr", 32'(ifc.out_addr), 32'(exp_addr));
            check("roundtrip_op", 32'(alu_ctrl_decode(ifc.out_instr[5:0])), 32'(o));
            exp_addr = exp_addr + ADDR_W'(1);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] srl_word;
    ifc.in_valid  = 1'b0;
    ifc.in_alu_op = 3'd0;
    ifc.in_rs     = 5'd0;
    ifc.in_rt     = 5'd0;
    ifc.in_rd     = 5'd0;
    ifc.in_shamt  = 5'd0;
    ifc.out_ready = 1'b0;
    reset = 1'b1;
    #12;
    check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_out_instr", ifc.out_instr, 32'd0);
    check("rst_out_addr", 32'(ifc.out_addr), 32'd0);
    check("rst_level", 32'(ifc.level), 32'd0);
    check("rst_err", 32'(ifc.err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // single add, one-cycle latency
    rdy_mode = 0;
    send(3'b010, 5'd1, 5'd2, 5'd3, 5'd0);
    check("lat_out_valid", 32'(ifc.out_valid), 32'd1);
    check("lat_out_instr", ifc.out_instr, 32'h0022_1820);
    check("lat_out_addr", 32'(ifc.out_addr), 32'd0);
    check("lat_level", 32'(ifc.level), 32'd1);
    rdy_mode = 1;
    wait_drain();
    check("pop1_out_addr", 32'(ifc.out_addr), 32'd1);
    check("pop1_level", 32'(ifc.level), 32'd0);

    // fill to full, then drain while the rest streams in
    rdy_mode = 0;
    send(3'b000, 5'd4, 5'd5, 5'd6, 5'd0);
    send(3'b001, 5'd7, 5'd8, 5'd9, 5'd0);
    send(3'b010, 5'd10, 5'd11, 5'd12, 5'd0);
    send(3'b100, 5'd13, 5'd14, 5'd15, 5'd0);
    @(negedge clk);
    check("full_in_ready", 32'(ifc.in_ready), 32'd0);
    check("full_level", 32'(ifc.level), 32'd4);
    check("full_head", ifc.out_instr, 32'h0085_3024);
    rdy_mode = 1;
    send(3'b101, 5'd16, 5'd17, 5'd18, 5'd0);
    send(3'b110, 5'd19, 5'd20, 5'd21, 5'd0);
    send(3'b111, 5'd22, 5'd23, 5'd24, 5'd0);
    wait_drain();
    // one word before plus seven here
    check("drain_out_addr", 32'(ifc.out_addr), 32'd8);

    // illegal op consumed, sticky err
    rdy_mode = 0;
    send(3'b011, 5'd1, 5'd1, 5'd1, 5'd0);
    check("illegal_level", 32'(ifc.level), 32'd0);
    check("illegal_err", 32'(ifc.err), 32'd1);
    check("illegal_out_valid", 32'(ifc.out_valid), 32'd0);
    send(3'b001, 5'd2, 5'd3, 5'd4, 5'd0);
    check("post_illegal_instr", ifc.out_instr, 32'h0043_2025);
    check("post_illegal_err", 32'(ifc.err), 32'd1);
    rdy_mode = 1;
    wait_drain();

    // random stream with backpressure; long enough to wrap out_addr
    rdy_mode = 2;
    for (int i = 0; i < 330; i++) begin
      send(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    rdy_mode = 1;
    wait_drain();
    check("rand_err", 32'(ifc.err), 32'(exp_err));
    check("rand_out_addr", 32'(ifc.out_addr), 32'(exp_addr));

    // asynchronous reset with words buffered
    rdy_mode = 0;
    send(3'b010, 5'd1, 5'd1, 5'd1, 5'd0);
    send(3'b110, 5'd2, 5'd2, 5'd2, 5'd0);
    send(3'b111, 5'd3, 5'd3, 5'd3, 5'd0);
    @(negedge clk);
    check("prerst_level", 32'(ifc.level), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("arst_level", 32'(ifc.level), 32'd0);
    check("arst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("arst_out_addr", 32'(ifc.out_addr), 32'd0);
    check("arst_err", 32'(ifc.err), 32'd0);
    check("arst_in_ready", 32'(ifc.in_ready), 32'd1);
    exp_q.delete();
    op_q.delete();
    exp_addr = '0;
    exp_err  = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // shamt field: only populated for srl when the option is built in
`ifdef RTYPE_ENC_SHAMT_EN
    srl_word = 32'h0004_28C2;
`else
    srl_word = 32'h0004_2802;
`endif
    send(3'b101, 5'd0, 5'd4, 5'd5, 5'd3);
    check("srl_shamt", ifc.out_instr, srl_word);
    check("srl_addr_after_rst", 32'(ifc.out_addr), 32'd0);
    rdy_mode = 1;
    send(3'b010, 5'd0, 5'd4, 5'd5, 5'd7);
    wait_drain();
    check("final_out_addr", 32'(ifc.out_addr), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
